uart_rx_receiver: RTL and testbench
===================================

Name: uart_rx_receiver

Overview:
UART receive front end, the counterpart of the Tx path. It samples the asynchronous serial line with an oversampling clock and deserializes LSB-first frames. Valid bytes are pushed into the Rx FIFO with a one-cycle write strobe, gated by the FIFO full flag. Framing, parity and overrun errors are reported to the APB UART register block.

Parameters:
OVERSAMPLE, 16, baud_clk cycles per bit; even, >= 4
DATA_BITS, 8, data bits per frame
SYNC_STAGES, 2, metastability flops on rx_serial; >= 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN

Ports:
baud_clk  in  1  single clock, OVERSAMPLE x baud rate
rst  in  1  synchronous reset, active-high
rx_serial  in  1  asynchronous serial line, idle high
RxFF  in  1  Rx FIFO full flag
clr_err  in  1  one-cycle clear for sticky overrun_err
data_out  out  DATA_BITS  last received byte, stable between writes
write_Rx  out  1  one-cycle push strobe to the Rx FIFO
framing_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch (0 when feature is off)
overrun_err  out  1  sticky: valid frame dropped because RxFF=1
busy  out  1  high in any state except IDLE

Behaviour:
- Reset, on a rst-high edge: sync flops=1, state=IDLE, counters=0, data_out=0, write_Rx=framing_err=parity_err=overrun_err=busy=0. Reset mid-frame abandons the frame with no strobe and no error.
- rx_s = rx_serial after SYNC_STAGES flops. All decisions use rx_s only.
- tick_cnt is clog2(OVERSAMPLE) wide. bit_cnt counts 0..DATA_BITS-1. Shift register fills right-shift, new bit in at the MSB (LSB-first on the line).
- IDLE: on rx_s=0, go to START with tick_cnt=0.
- START: increment tick_cnt. At tick_cnt=OVERSAMPLE/2-1, sample rx_s:
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: glitch. Return to IDLE with no error.
- DATA: at tick_cnt=OVERSAMPLE-1, sample rx_s into the shift register, tick_cnt=0, bit_cnt+1. After bit DATA_BITS-1 is sampled, go to PARITY (feature on) or STOP.
- STOP: at tick_cnt=OVERSAMPLE-1 (mid stop bit), sample rx_s:
  - 1 with no parity error, RxFF=0: on the next edge data_out<=shift register and write_Rx=1 for exactly one cycle. Go to IDLE.
  - 1 with no parity error, RxFF=1: byte dropped, data_out unchanged, overrun_err<=1. Go to IDLE.
  - 0: framing_err pulses one cycle, no write. Go to BREAK.
  - Sampled RxFF is the value in the stop-sample cycle.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- overrun_err holds until clr_err=1. If set and clear coincide, set wins.
- Back-to-back frames: a start edge is accepted from half a stop bit onward. No idle gap is required.
- Errors never cause a write. Parity is checked before framing. If both fail, both pulses fire in the same cycle.
- Latency: the write_Rx edge comes 1 cycle after the mid-stop sample. That is about SYNC_STAGES+1+OVERSAMPLE/2-1+(DATA_BITS+1)xOVERSAMPLE+1 cycles after the falling start edge.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds a PARITY state after DATA. It samples at tick_cnt=OVERSAMPLE-1 and compares the sample with the XOR of the data bits, XORed with PARITY_ODD. On mismatch, parity_err pulses in the stop-sample cycle and the byte is not written. The frame is 1 start + DATA_BITS + 1 parity + 1 stop.
- Undefined: no PARITY state, parity_err tied to 0, and the frame is 1 start + DATA_BITS + 1 stop.

Test Plan:
1. OVERSAMPLE=16, RxFF=0, frame 0xA5 (start edge at t0) -> single write_Rx pulse at t0+155, data_out=0xA5; no error outputs.
2. rx_serial low for 4 cycles, then high -> back to IDLE, busy drops within 12 cycles; write_Rx and all errors stay 0.
3. Frame 0x3C with stop bit 0, line held low 40 cycles, then frame 0x11 -> framing_err one pulse, no write; then write_Rx with data_out=0x11.
4. Write 0x42, then RxFF=1 during frame 0x55 -> no write, data_out stays 0x42, overrun_err=1 and held; clr_err pulse -> overrun_err=0.
5. rst asserted during data bit 3 of frame 0xF0 -> all outputs 0 on the next edge; the following frame 0x81 is received as 0x81.
6. With UART_RX_PARITY_EN and PARITY_ODD=0, 0x07 sent with parity bit 0 -> parity_err pulse, no write; resent with parity bit 1 -> write_Rx, data_out=0x07.

Source files
------------

// File: rtl/uart_rx_receiver_if.sv
// Rx FIFO push port of the UART receiver: byte, push strobe and FIFO-full flag.
// Latency: none (wires only).
// Backpressure: RxFF from the FIFO side; the receiver drops the frame instead of stalling.
interface uart_rx_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;   // last received byte
    logic                 write_Rx;   // one-cycle push strobe
    logic                 RxFF;       // FIFO full flag

    modport master (output data_out, output write_Rx, input RxFF);
    modport slave  (input data_out, input write_Rx, output RxFF);
endinterface

// File: rtl/uart_rx_receiver.sv
// Purpose: oversampled UART receiver, LSB-first frames pushed into the Rx FIFO; parity via UART_RX_PARITY_EN.
// Latency: write_Rx one cycle after mid-stop sample, ~SYNC_STAGES+OVERSAMPLE/2+(DATA_BITS+1)*OVERSAMPLE+1 from start edge.
// Backpressure: none toward the line; a good frame seen while RxFF=1 is dropped and sets sticky overrun_err.
// Ports: baud_clk/rst (sync, active-high); rx_serial async line (idle high); clr_err clears overrun_err;
//        fifo (master) drives data_out/write_Rx and reads RxFF; framing_err/parity_err are one-cycle
//        pulses in the stop-sample cycle; overrun_err is sticky; busy is high outside IDLE.
module uart_rx_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                baud_clk,
    input  logic                rst,
    input  logic                rx_serial,
    input  logic                clr_err,
    uart_rx_receiver_if.master  fifo,
    output logic                framing_err,
    output logic                parity_err,
    output logic                overrun_err,
    output logic                busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("OVERSAMPLE must be even and >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [TW-1:0]          tick_q, tick_nxt;
    logic [BW-1:0]          bit_q, bit_nxt;
    logic [DATA_BITS-1:0]   shift_q, shift_nxt;
    logic                   par_bad_q, par_bad_nxt;   // parity verdict held until the stop sample
    logic                   perr_q, perr_nxt;
    logic                   wr_nxt, ferr_nxt, ovr_set;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign busy       = (state_q != ST_IDLE);
    assign parity_err = perr_q;   // never set when the parity state is absent

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            sync_q        <= '1;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_bad_q     <= 1'b0;
            perr_q        <= 1'b0;
            framing_err   <= 1'b0;
            overrun_err   <= 1'b0;
            fifo.write_Rx <= 1'b0;
            fifo.data_out <= '0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], rx_serial};
            tick_q        <= tick_nxt;
            bit_q         <= bit_nxt;
            shift_q       <= shift_nxt;
            par_bad_q     <= par_bad_nxt;
            perr_q        <= perr_nxt;
            framing_err   <= ferr_nxt;
            fifo.write_Rx <= wr_nxt;
            if (wr_nxt) begin
                fifo.data_out <= shift_q;
            end
            // A set in the same cycle as a clear must win.
            if (ovr_set) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state_q;
        tick_nxt    = tick_q;
        bit_nxt     = bit_q;
        shift_nxt   = shift_q;
        par_bad_nxt = par_bad_q;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        wr_nxt      = 1'b0;
        ovr_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt   = ST_START;
                    tick_nxt    = '0;
                    par_bad_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (tick_q == TICK_HALF) begin
                    // Still low at mid start bit: real start; otherwise a glitch.
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    tick_nxt = tick_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_nxt                 = '0;
                    shift_nxt                = shift_q >> 1;
                    shift_nxt[DATA_BITS-1]   = rx_s;
                    if (bit_q == BIT_LAST) begin
                        bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        bit_nxt = bit_q + BW'(1);
                    end
                end else begin
                    tick_nxt = tick_q + TW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_nxt    = '0;
                    par_bad_nxt = (rx_s != ((^shift_q) ^ (PARITY_ODD != 0)));
                    state_nxt   = ST_STOP;
                end else begin
                    tick_nxt = tick_q + TW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_nxt = '0;
                    perr_nxt = par_bad_q;
                    ferr_nxt = !rx_s;
                    if (!rx_s) begin
                        state_nxt = ST_BREAK;
                    end else begin
                        state_nxt = ST_IDLE;
                        if (!par_bad_q) begin
                            if (fifo.RxFF) begin
                                ovr_set = 1'b1;
                            end else begin
                                wr_nxt = 1'b1;
                            end
                        end
                    end
                end else begin
                    tick_nxt = tick_q + TW'(1);
                end
            end
            ST_BREAK: begin
                // Hold here until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_receiver.sv
// Testbench for uart_rx_receiver: randomized frames checked against a frame-level scoreboard.
// Expected write/error pulses are queued with their cycle when a frame is sent; a monitor pops them.
// Build with UART_RX_PARITY_EN defined to also exercise the parity frames.
module tb_uart_rx_receiver;
    localparam int OS   = 16;
    localparam int SYNC = 2;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Cycles from driving the start edge to the write/error pulse.
    localparam int LAT = SYNC + 1 + OS / 2 - 1 + (8 + 1) * OS + 1 + (PAR_EN ? OS : 0);

    logic baud_clk = 1'b0;
    logic rst, rx_serial, clr_err;
    logic framing_err, parity_err, overrun_err, busy;

    uart_rx_receiver_if #(.DATA_BITS(8)) fifo_if ();

    uart_rx_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8), .SYNC_STAGES(SYNC), .PARITY_ODD(0)) dut (
        .baud_clk    (baud_clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .clr_err     (clr_err),
        .fifo        (fifo_if),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 baud_clk = ~baud_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_wr_cyc[$];
    logic [7:0] exp_wr_dat[$];
    int exp_fe_cyc[$];
    int exp_pe_cyc[$];
    logic [7:0] model_dat = 8'h00;
    bit model_ovr = 1'b0;
    bit ovr_prev = 1'b0;
    int ovr_rise_cyc = -1;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge baud_clk) cyc = cyc + 1;

    // Monitor: every pulse must match the head of its expectation queue.
    always @(posedge baud_clk) begin
        #1;
        if (fifo_if.write_Rx) begin
            chk_eq("wr_pending", 32'(exp_wr_cyc.size() != 0), 32'd1);
            if (exp_wr_cyc.size() != 0) begin
                chk_eq("wr_cycle", cyc, exp_wr_cyc.pop_front());
                chk_eq("wr_data", fifo_if.data_out, exp_wr_dat.pop_front());
            end
        end
        if (framing_err) begin
            chk_eq("fe_pending", 32'(exp_fe_cyc.size() != 0), 32'd1);
            if (exp_fe_cyc.size() != 0) chk_eq("fe_cycle", cyc, exp_fe_cyc.pop_front());
        end
        if (parity_err) begin
            chk_eq("pe_pending", 32'(exp_pe_cyc.size() != 0), 32'd1);
            if (exp_pe_cyc.size() != 0) chk_eq("pe_cycle", cyc, exp_pe_cyc.pop_front());
        end
        if (overrun_err && !ovr_prev) ovr_rise_cyc = cyc;
        ovr_prev = overrun_err;
    end

    // Called at posedge+1; holds the line at v for n cycles and returns at posedge+1.
    task automatic drive(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    // Sends one frame and records what a correct receiver must produce, from the frame rules alone.
    task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_v,
                              input int stop_len, input int idle_after, output int t_ev);
        bit par_ok;
        par_ok = !PAR_EN || (par_v == ((^d) ^ PODD));
        t_ev = cyc + LAT;
        if (!stop_v) exp_fe_cyc.push_back(t_ev);
        if (!par_ok) exp_pe_cyc.push_back(t_ev);
        if (stop_v && par_ok) begin
            if (fifo_if.RxFF) begin
                model_ovr = 1'b1;
            end else begin
                exp_wr_cyc.push_back(t_ev);
                exp_wr_dat.push_back(d);
                model_dat = d;
            end
        end
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
        if (PAR_EN) drive(par_v, OS);
        drive(stop_v, stop_len);
        if (idle_after > 0) drive(1'b1, idle_after);
    endtask

    function automatic bit good_par(input logic [7:0] d);
        return (^d) ^ PODD;
    endfunction

    initial begin
        logic [7:0] d;
        bit stop_v, par_v, prev_long;
        int slen, idle, t_ev, waited;

        rst = 1'b1; rx_serial = 1'b1; clr_err = 1'b0; fifo_if.RxFF = 1'b0;
        repeat (3) @(posedge baud_clk);
        #1;
        chk_eq("rst_data_out", fifo_if.data_out, 8'h00);
        chk_eq("rst_write", fifo_if.write_Rx, 1'b0);
        chk_eq("rst_ferr", framing_err, 1'b0);
        chk_eq("rst_perr", parity_err, 1'b0);
        chk_eq("rst_ovr", overrun_err, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        rst = 1'b0;
        drive(1'b1, 5);

        // Single clean frame; the monitor checks the cycle of the pulse.
        send_frame(8'hA5, 1'b1, good_par(8'hA5), OS, 10, t_ev);
        chk_eq("a5_data", fifo_if.data_out, 8'hA5);
        chk_eq("a5_queue", exp_wr_cyc.size(), 0);

        // Short glitch on the line: start is rejected silently.
        drive(1'b0, 4);
        chk_eq("glitch_busy_hi", busy, 1'b1);
        rx_serial = 1'b1;
        waited = 0;
        while (busy && waited < 12) begin
            @(posedge baud_clk); #1;
            waited++;
        end
        chk_eq("glitch_busy_lo", busy, 1'b0);
        drive(1'b1, 10);

        // Framing error then a long low line: one pulse, no retrigger, then a good frame.
        send_frame(8'h3C, 1'b0, good_par(8'h3C), OS, 0, t_ev);
        drive(1'b0, 40);
        drive(1'b1, 20);
        chk_eq("fe_queue", exp_fe_cyc.size(), 0);
        chk_eq("fe_busy", busy, 1'b0);
        send_frame(8'h11, 1'b1, good_par(8'h11), OS, 10, t_ev);
        chk_eq("after_fe_data", fifo_if.data_out, 8'h11);

        // Overrun: frame dropped, data_out holds, flag sticky until clr_err.
        send_frame(8'h42, 1'b1, good_par(8'h42), OS, 4, t_ev);
        fifo_if.RxFF = 1'b1;
        send_frame(8'h55, 1'b1, good_par(8'h55), OS, 50, t_ev);
        chk_eq("ovr_data_hold", fifo_if.data_out, 8'h42);
        chk_eq("ovr_sticky", overrun_err, model_ovr);
        clr_err = 1'b1;
        drive(1'b1, 1);
        clr_err = 1'b0;
        model_ovr = 1'b0;
        chk_eq("ovr_cleared", overrun_err, 1'b0);

        // clr_err held across the set: the set wins for one cycle.
        ovr_rise_cyc = -1;
        clr_err = 1'b1;
        send_frame(8'h9E, 1'b1, good_par(8'h9E), OS, 0, t_ev);
        chk_eq("ovr_set_wins", ovr_rise_cyc, t_ev);
        chk_eq("ovr_then_clr", overrun_err, 1'b0);
        clr_err = 1'b0;
        model_ovr = 1'b0;

        // Leave overrun set and data_out non-zero, then reset in data bit 3 of 0xF0.
        send_frame(8'h66, 1'b1, good_par(8'h66), OS, 4, t_ev);
        fifo_if.RxFF = 1'b0;
        chk_eq("pre_rst_ovr", overrun_err, 1'b1);
        drive(1'b0, OS);
        drive(1'b0, 3 * OS);
        drive(1'b0, OS / 2);
        rst = 1'b1;
        @(posedge baud_clk); #1;
        chk_eq("mid_rst_data", fifo_if.data_out, 8'h00);
        chk_eq("mid_rst_ovr", overrun_err, 1'b0);
        chk_eq("mid_rst_busy", busy, 1'b0);
        chk_eq("mid_rst_write", fifo_if.write_Rx, 1'b0);
        rst = 1'b0;
        model_dat = 8'h00;
        model_ovr = 1'b0;
        drive(1'b1, 20);
        send_frame(8'h81, 1'b1, good_par(8'h81), OS, 10, t_ev);
        chk_eq("post_rst_data", fifo_if.data_out, 8'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, OS, 10, t_ev);
        chk_eq("par_bad_nowrite", fifo_if.data_out, 8'h81);
        send_frame(8'h07, 1'b1, 1'b1, OS, 10, t_ev);
        chk_eq("par_good_data", fifo_if.data_out, 8'h07);
        send_frame(8'h07, 1'b0, 1'b0, OS, 10, t_ev);
        chk_eq("par_fe_queues", exp_pe_cyc.size() + exp_fe_cyc.size(), 0);
`endif

        // Random frames: back-to-back starts from mid stop bit, random RxFF, errors and clears.
        prev_long = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if (prev_long) begin
                chk_eq("rnd_ovr", overrun_err, model_ovr);
                chk_eq("rnd_data", fifo_if.data_out, model_dat);
                fifo_if.RxFF = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    clr_err = 1'b1;
                    drive(1'b1, 1);
                    clr_err = 1'b0;
                    model_ovr = 1'b0;
                end
            end
            d = 8'($urandom);
            stop_v = ($urandom_range(0, 7) != 0);
            par_v = good_par(d) ^ ($urandom_range(0, 5) == 0);
            if (stop_v && ($urandom_range(0, 1) == 1)) begin
                slen = OS / 2 + 2;
                idle = 0;
            end else begin
                slen = OS;
                idle = stop_v ? $urandom_range(0, 5) : 4;
            end
            send_frame(d, stop_v, par_v, slen, idle, t_ev);
            prev_long = (slen == OS);
        end

        drive(1'b1, 60);
        chk_eq("end_wr_queue", exp_wr_cyc.size(), 0);
        chk_eq("end_fe_queue", exp_fe_cyc.size(), 0);
        chk_eq("end_pe_queue", exp_pe_cyc.size(), 0);
        chk_eq("end_ovr", overrun_err, model_ovr);
        chk_eq("end_data", fifo_if.data_out, model_dat);
        chk_eq("end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
